// File: rtl/matrix_stream_pkg.sv
// Shared types and constants for the matrix stream arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_stream_pkg;

    // Arbiter FSM encoding: IDLE searches for a requester, LOCKED passes one packet.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int DATA_W_DEFAULT = 32;
    localparam int PKT_CNT_W      = 32;

endpackage

// File: rtl/rr_select.sv
// Rotate-priority picker: first asserted request at or after rr_ptr, wrapping mod NUM_SRC.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a pure function of its inputs.
// Ports: req (request vector), rr_ptr (search start), found (any request), winner (index).
module rr_select
    import matrix_stream_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 3
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   rr_ptr,
    output logic               found,
    output logic [SEL_W-1:0]   winner
);

    int base;
    int idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        base   = int'(rr_ptr);
        idx    = 0;
        // Wrap is mod NUM_SRC, not mod 2**SEL_W; an out-of-range pointer restarts at 0.
        if (base >= NUM_SRC) begin
            base = 0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = base + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/matrix_stream_arbiter.sv
// Packet-locked round-robin arbiter sharing one AXI-Stream sink among NUM_SRC sources.
// Latency: 1 cycle to arbitrate, then zero-latency combinational pass-through per beat.
// Backpressure: m_tready routed only to the granted source; grant held until the TLAST handshake.
// Ports: clk/reset (sync, active-high); s_t* per-source stream in; m_t* stream out;
//        grant_id/busy expose the lock; pkt_count counts completed packets.
// Optional: define MATRIX_STREAM_ARBITER_PKT_CNT_EN to build the packet counter, else pkt_count=0.
module matrix_stream_arbiter
    import matrix_stream_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int SEL_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        s_tvalid,
    input  logic [NUM_SRC-1:0]        s_tlast,
    input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
    output logic [NUM_SRC-1:0]        s_tready,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    output logic [DATA_W-1:0]         m_tdata,
    input  logic                      m_tready,
    output logic [SEL_W-1:0]          grant_id,
    output logic                      busy,
    output logic [PKT_CNT_W-1:0]      pkt_count
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             sel_found;
    logic [SEL_W-1:0] sel_winner;
    logic             locked;
    logic             eop;

    rr_select #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_rr_select (
        .req    (s_tvalid),
        .rr_ptr (rr_ptr_q),
        .found  (sel_found),
        .winner (sel_winner)
    );

    assign locked = (state_q == ST_LOCKED);

    // Datapath mux. While idle the source-0 lane is presented so m_tdata/m_tlast
    // are never X, but m_tvalid and every s_tready stay low.
    always_comb begin
        m_tdata  = s_tdata[DATA_W-1:0];
        m_tlast  = s_tlast[0];
        m_tvalid = 1'b0;
        s_tready = '0;
        if (locked) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_q == SEL_W'(i)) begin
                    m_tdata     = s_tdata[i*DATA_W +: DATA_W];
                    m_tlast     = s_tlast[i];
                    m_tvalid    = s_tvalid[i];
                    s_tready[i] = m_tready;
                end
            end
        end
    end

    assign eop = m_tvalid & m_tready & m_tlast;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d = ST_LOCKED;
                    grant_d = sel_winner;
                end
            end
            ST_LOCKED: begin
                // Unlocking on the TLAST edge forces one idle cycle before the next grant,
                // and moving the pointer past the finisher gives it lowest priority.
                if (eop) begin
                    state_d = ST_IDLE;
                    if (int'(grant_q) >= NUM_SRC - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign busy     = locked;
    assign grant_id = grant_q;

`ifdef MATRIX_STREAM_ARBITER_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // Free-running count of completed packets; wraps naturally at 2**PKT_CNT_W.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (eop) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_count = pkt_cnt_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: doc/matrix_stream_arbiter.md
Name: matrix_stream_arbiter

Overview:
- Packet-locked round-robin arbiter that shares the single 32-bit AXI-Stream input of the matrix multiplier between NUM_SRC matrix generator sources.
- Grant is held for a whole matrix packet, from the first beat through the beat with TLAST, so rows from different matrices never interleave.
- Sits between the MatrixGeneratorRT instances and the multiplier input_r_* port.

Parameters:
- NUM_SRC, 2, number of requesting stream sources (2..8).
- DATA_W, 32, TDATA width.
- SEL_W, 3, grant index width; must satisfy 2**SEL_W >= NUM_SRC.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s_tvalid  in  NUM_SRC  per-source TVALID.
- s_tlast  in  NUM_SRC  per-source TLAST.
- s_tdata  in  NUM_SRC*DATA_W  per-source TDATA; source i occupies bits [i*DATA_W +: DATA_W].
- s_tready  out  NUM_SRC  per-source TREADY.
- m_tvalid  out  1  to multiplier input_r_TVALID.
- m_tlast  out  1  to multiplier input_r_TLAST.
- m_tdata  out  DATA_W  to multiplier input_r_TDATA.
- m_tready  in  1  from multiplier input_r_TREADY.
- grant_id  out  SEL_W  index of the locked source; valid while busy.
- busy  out  1  high while a packet is locked.
- pkt_count  out  32  completed packets; feature-dependent (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high, on the clk edge):
  - state=IDLE; grant_id=0; rr_ptr=0; pkt_count=0.
  - busy=0, m_tvalid=0, s_tready=0.
- State IDLE:
  - Search s_tvalid starting at rr_ptr, wrapping modulo NUM_SRC; the first asserted source wins.
  - If a winner exists, register grant_id and go to LOCKED on the next edge.
  - If no source is valid, stay in IDLE.
  - Arbitration latency is 1 cycle.
- State LOCKED:
  - busy=1.
  - m_tvalid = s_tvalid[grant_id]; m_tdata and m_tlast are muxed from the granted source.
  - s_tready[grant_id] = m_tready; all other s_tready bits = 0.
  - The datapath is combinational pass-through: zero added latency, no buffering.
- End of packet: on a handshake (m_tvalid & m_tready & m_tlast):
  - Return to IDLE on the same edge.
  - rr_ptr = (grant_id+1) mod NUM_SRC.
  - This inserts exactly one idle bubble cycle between packets.
- Stall rules inside LOCKED:
  - Source deasserts TVALID mid-packet: the grant is held indefinitely; no timeout.
  - m_tready low: the grant is held and the granted source sees s_tready=0.
- Outputs while in IDLE:
  - m_tvalid=0 and all s_tready=0.
  - m_tdata and m_tlast must be driven from the source 0 mux (deterministic, don't-care to the sink).
- Single-beat packet (TLAST on the first beat): lock for one handshake, then IDLE.
- Simultaneous requests: rr_ptr decides; a source that just finished has lowest priority next round.
- Reset mid-packet: the grant is dropped on the reset edge and outputs take their reset values. The partially sent packet is not completed; the sink must also be reset.
- A source whose index is >= NUM_SRC never exists; wrap arithmetic is mod NUM_SRC, not mod 2**SEL_W.

Optional Feature:
- Macro: MATRIX_STREAM_ARBITER_PKT_CNT_EN.
- Defined: pkt_count increments by 1 on each end-of-packet handshake, wraps from 0xFFFFFFFF to 0, and clears on reset.
- Undefined: pkt_count is tied to 0 and no counter register is synthesized.

Decomposition:
- Shared package matrix_stream_pkg holds:
  - the state encoding constants ST_IDLE=1'b0, ST_LOCKED=1'b1;
  - default DATA_W=32;
  - the count width constant PKT_CNT_W=32.
- One sub-module is natural: rr_select.
  - Purely combinational rotate-priority picker.
  - Inputs: request vector and rr_ptr.
  - Outputs: found flag and winner index.
  - Keeps the FSM file small and allows unit-testing the wrap logic.

Test Plan:
1. Reset held 50 cycles with all s_tvalid=1 -> m_tvalid=0, s_tready=0, busy=0, grant_id=0, pkt_count=0 throughout.
2. NUM_SRC=2, only src0 sends a 4-beat packet (data 1..4, TLAST on 4), m_tready=1 -> grant_id=0 one cycle after valid; m_tdata sequence 1,2,3,4 on consecutive cycles; busy falls after beat 4; pkt_count=1.
3. Both sources continuously valid with 3-beat packets (src0 0xA0.., src1 0xB0..) -> packets alternate src0,src1,src0,src1; exactly one m_tvalid=0 bubble between packets; no interleaved beats.
4. m_tready=0 for 10 cycles mid-packet of src1 -> m_tdata held stable, s_tready=2'b00, grant_id stays 1; the packet completes after m_tready returns.
5. src0 drops TVALID for 5 cycles mid-packet while src1 is valid -> grant stays 0, src1 sees s_tready=0; src1 is granted only after src0's TLAST beat.
6. Assert reset on beat 2 of a 5-beat packet -> next edge busy=0, m_tvalid=0, pkt_count=0; after release, arbitration restarts from source 0. With MATRIX_STREAM_ARBITER_PKT_CNT_EN undefined, pkt_count remains 0 in every scenario.
